// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin, packet-locked arbiter sharing one UART transmitter
//            among REQ_NUM byte streams, with a completion watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int REQ_NUM = 4,
  parameter int TIMEOUT = 600_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REQ_NUM-1:0]     req_valid,
  input  logic [8*REQ_NUM-1:0]   req_data,
  input  logic [REQ_NUM-1:0]     req_last,
  output logic [REQ_NUM-1:0]     req_ready,
  output logic [REQ_NUM-1:0]     grant,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  input  logic                   tx_done,
  output logic                   timeout_err
);

  localparam int c_PTR_W = $clog2(REQ_NUM);
  localparam int c_SUM_W = c_PTR_W + 1;
  localparam int c_CNT_W = $clog2(TIMEOUT);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
  localparam logic [c_PTR_W-1:0] c_PTR_RST  = c_PTR_W'(REQ_NUM - 1);
  localparam logic [REQ_NUM-1:0] c_ONE      = REQ_NUM'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_PTR_W-1:0]   r_ptr, w_ptr_nxt;
  logic                 r_last, w_last_nxt;
  logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [REQ_NUM-1:0]   r_grant, w_grant_nxt;
  logic [REQ_NUM-1:0]   r_ready, w_ready_nxt;
  logic [7:0]           r_data, w_data_nxt;
  logic                 r_start, w_start_nxt;
  logic                 r_timeout, w_timeout_nxt;

  logic [7:0]           w_bytes [REQ_NUM];
  logic [c_SUM_W-1:0]   w_sum;
  logic [c_PTR_W-1:0]   w_cand;
  logic [c_PTR_W-1:0]   w_win;
  logic                 w_any;
  logic [c_PTR_W-1:0]   w_sel;
  logic [REQ_NUM-1:0]   w_onehot;
  logic                 w_capture;

  for (genvar g = 0; g < REQ_NUM; g++) begin : g_bytes
    assign w_bytes[g] = req_data[8*g +: 8];
  end

  // First valid requester after the last winner, wrapping around.
  always_comb begin
    w_any  = 1'b0;
    w_win  = '0;
    w_sum  = '0;
    w_cand = '0;
    for (int i = 1; i <= REQ_NUM; i++) begin
      w_sum  = {1'b0, r_ptr} + c_SUM_W'(i);
      w_cand = (w_sum >= c_SUM_W'(REQ_NUM)) ? c_PTR_W'(w_sum - c_SUM_W'(REQ_NUM))
                                            : c_PTR_W'(w_sum);
      if (!w_any && req_valid[w_cand]) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
    end
  end

  assign w_sel    = (r_state == S_HOLD) ? r_ptr : w_win;
  assign w_onehot = c_ONE << w_sel;

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_last_nxt    = r_last;
    w_cnt_nxt     = r_cnt;
    w_grant_nxt   = r_grant;
    w_ready_nxt   = '0;
    w_data_nxt    = r_data;
    w_start_nxt   = 1'b0;
    w_timeout_nxt = 1'b0;
    w_capture     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!tx_busy && w_any) begin
          w_capture   = 1'b1;
          w_grant_nxt = w_onehot;
          w_ptr_nxt   = w_win;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        w_start_nxt = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt + c_CNT_W'(1);
        // Completion takes priority over a coincident watchdog expiry.
        if (tx_done) begin
          if (r_last) begin
            w_grant_nxt = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_HOLD;
          end
        end else if (r_cnt == c_CNT_LAST) begin
          w_timeout_nxt = 1'b1;
          w_grant_nxt   = '0;
          w_state_nxt   = S_IDLE;
        end
      end
      S_HOLD: begin
        w_cnt_nxt = r_cnt + c_CNT_W'(1);
        if (req_valid[r_ptr] && !tx_busy) begin
          w_capture   = 1'b1;
          w_state_nxt = S_SEND;
        end else if (r_cnt == c_CNT_LAST) begin
          w_timeout_nxt = 1'b1;
          w_grant_nxt   = '0;
          w_state_nxt   = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_capture) begin
      w_ready_nxt = w_onehot;
      w_data_nxt  = w_bytes[w_sel];
      w_last_nxt  = req_last[w_sel];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= c_PTR_RST;
      r_last    <= 1'b0;
      r_cnt     <= '0;
      r_grant   <= '0;
      r_ready   <= '0;
      r_data    <= 8'h00;
      r_start   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_last    <= w_last_nxt;
      r_cnt     <= w_cnt_nxt;
      r_grant   <= w_grant_nxt;
      r_ready   <= w_ready_nxt;
      r_data    <= w_data_nxt;
      r_start   <= w_start_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign req_ready   = r_ready;
  assign grant       = r_grant;
  assign tx_data     = r_data;
  assign tx_start    = r_start;
  assign timeout_err = r_timeout;

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter among `REQ_NUM` byte-stream requesters. It sits between the producer blocks (command responders, status reporters, loopback paths) and a single `uart_tx` instance. Each grant is held for a whole packet, delimited by a per-requester `last` flag. A watchdog releases the transmitter if it never reports completion.

## Interface
Parameters:
- `REQ_NUM`, default 4: number of requesters; must be ≥ 2.
- `TIMEOUT`, default 'd600_000: maximum cycles to wait for `tx_done`, or for the next byte of a locked packet; must be ≥ 2.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  REQ_NUM  per-requester byte-available flag.
- `req_data`  in  8*REQ_NUM  byte for requester i, on bits [8i+7:8i].
- `req_last`  in  REQ_NUM  marks the final byte of a packet; sampled together with the data.
- `req_ready`  out  REQ_NUM  registered one-cycle pulse; the byte was captured.
- `grant`  out  REQ_NUM  one-hot owner of the transmitter; all zero when free.
- `tx_data`  out  8  byte to the transmitter; held stable until the next capture.
- `tx_start`  out  1  one-cycle pulse that starts a transmission.
- `tx_busy`  in  1  transmitter is currently shifting.
- `tx_done`  in  1  one-cycle pulse when the stop bit completes.
- `timeout_err`  out  1  one-cycle pulse on watchdog expiry.

## Operation
- **State machine:** IDLE, SEND, WAIT, HOLD.
- **Registers:**
  - `ptr`: index of the last granted requester.
  - `last_q`: latched `req_last` of the current byte.
  - `cnt`: watchdog counter, width $clog2(TIMEOUT).
- **IDLE**
  - Requires `tx_busy`=0 and at least one `req_valid`.
  - Winner is the first valid index searching upward from `ptr+1`, wrapping modulo `REQ_NUM`.
  - On the clock edge: `grant` ← one-hot winner, `ptr` ← winner, `tx_data` ← winner's byte, `last_q` ← winner's `req_last`, `req_ready[winner]` ← 1; go to SEND.
- **SEND**
  - `tx_start` ← 1 and `cnt` ← 0; go to WAIT.
- **WAIT**
  - `cnt` increments each cycle.
  - On `tx_done` with `last_q`=1: `grant` ← 0; go to IDLE.
  - On `tx_done` with `last_q`=0: `cnt` ← 0; go to HOLD.
  - If `cnt` = TIMEOUT-1 without `tx_done`: pulse `timeout_err`, `grant` ← 0; go to IDLE.
- **HOLD**
  - Only the granted requester is considered; all others are ignored.
  - If its `req_valid`=1 and `tx_busy`=0: capture exactly as in IDLE; `grant` and `ptr` are unchanged; go to SEND.
  - `cnt` increments each cycle; on expiry, same action as the WAIT timeout.
- **Outputs and ignored inputs**
  - `req_ready` and `tx_start` are high for exactly one cycle per captured byte.
  - `tx_done` outside WAIT is ignored.
- **Boundary rules**
  - `tx_done` and watchdog expiry in the same cycle: `tx_done` wins.
  - A granted requester that drops `req_valid` mid-packet keeps the grant until `last` or timeout.
  - `ptr` advances only on a grant, so after a timeout the next search begins with the following requester.
  - `ptr` wraps from REQ_NUM-1 to 0.
  - `tx_busy`=1 blocks capture in IDLE and HOLD; the FSM stays in place, and in HOLD `cnt` still runs.

## Timing
- **Reset values:** `grant`=0, `req_ready`=0, `tx_data`=8'h00, `tx_start`=0, `timeout_err`=0, state=IDLE, `cnt`=0, `last_q`=0, `ptr`=REQ_NUM-1 (so requester 0 wins first). Reset mid-transfer aborts immediately, without `timeout_err`.
- **Capture and start:**
  - `req_valid` seen in IDLE in cycle N → `grant` and `req_ready` high in cycle N+1 → `tx_start` high in cycle N+2, with `tx_data` already valid since N+1.
  - The requester must hold `req_valid`, `req_data` and `req_last` until it samples `req_ready`. It may present its next byte from the cycle after `req_ready`.
- **Release:** `tx_done` in cycle M with `last_q`=1 → `grant`=0 in M+1. A new arbitration can capture in M+1, giving `grant` in M+2.
- **Watchdog:** fires TIMEOUT cycles after entering WAIT or HOLD. `timeout_err` and `grant`=0 take effect in the same cycle.

## Test plan
1. **Single byte:** requester 0 sends 8'hA5 with last=1 at cycle 0 → `grant`=4'b0001 and `req_ready`=4'b0001 in cycle 1; `tx_data`=A5 and one `tx_start` pulse in cycle 2; after `tx_done`, `grant`=0 one cycle later.
2. **Round robin:** all four requesters valid simultaneously with single bytes 8'h10, 8'h20, 8'h30, 8'h40 (last=1), re-asserted after each `req_ready` → service order 0,1,2,3,0,1,… with exactly one `tx_start` per byte.
3. **Packet lock:** requester 1 sends 8'h11, 8'h22, 8'h33 (last on 8'h33) while requester 2 is continuously valid → `grant`=4'b0010 throughout; requester 2 is granted only after the `tx_done` of 8'h33.
4. **Watchdog:** TIMEOUT=16, `tx_done` never asserted → `timeout_err` pulses 16 cycles after entering WAIT; `grant` clears; requester 1 is served next.
5. **Busy gating:** `tx_busy`=1 while requester 3 is valid → no `grant` and no `req_ready`; `tx_busy` falls → `grant`=4'b1000 on the next edge.
6. **Reset mid-WAIT:** assert `rst` for one cycle → all outputs zero on the next cycle; with requesters 0 and 2 both valid afterwards, requester 0 is granted first.
